// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage program counter with flush, ready handshake and stalled-branch capture
module pc_gen #(
    parameter int unsigned ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter int unsigned STEP         = 4,
    parameter int unsigned STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               if_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending,
    output logic               pc_misaligned
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              adv;

    // Only stall[0] governs the PC; the upper bits belong to later pipeline stages.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign adv = !stall[0] && if_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ce_d        = ce_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
            ce_d    = 1'b1;
            if (flush) begin
                pc_d = new_pc;
            end
        end else begin
            if (flush) begin
                pc_d   = new_pc;
                pend_d = 1'b0;
            end else if (branch_flag_i && adv) begin
                pc_d   = branch_target_address_i;
                pend_d = 1'b0;
            end else if (branch_flag_i) begin
                // Stalled branch: remember the newest target until the PC may move.
                pend_d      = 1'b1;
                pend_addr_d = branch_target_address_i;
            end else if (pend_q && adv) begin
                pc_d   = pend_addr_q;
                pend_d = 1'b0;
            end else if (adv) begin
                pc_d = pc_q + STEP_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign pc               = pc_q;
    assign ce               = ce_q;
    assign redirect_pending = pend_q;
    assign pc_misaligned    = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;
    logic        if_ready = 1'b1;
    logic [31:0] pc;
    logic        ce, pend, mis;

    logic        rst8 = 1'b1;
    logic [5:0]  stall8 = '0;
    logic        flush8 = 1'b0;
    logic [7:0]  new_pc8 = '0;
    logic        br8 = 1'b0;
    logic [7:0]  tgt8 = '0;
    logic        ready8 = 1'b1;
    logic [7:0]  pc8;
    logic        ce8, pend8, mis8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag_i(br), .branch_target_address_i(tgt), .if_ready(if_ready),
        .pc(pc), .ce(ce), .redirect_pending(pend), .pc_misaligned(mis)
    );

    pc_gen #(.ADDR_W(8), .RESET_VECTOR(32'h0000_00F8), .STEP(4), .STALL_W(6)) dut8 (
        .clk(clk), .rst(rst8), .stall(stall8), .flush(flush8), .new_pc(new_pc8),
        .branch_flag_i(br8), .branch_target_address_i(tgt8), .if_ready(ready8),
        .pc(pc8), .ce(ce8), .redirect_pending(pend8), .pc_misaligned(mis8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = '0; if_ready = 1'b1; flush = 1'b0; br = 1'b0;
        step(); step();
        checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc: got %h exp 80000000", pc); end
        checks++; if (ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b exp 0", ce); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b exp 0", pend); end
        rst = 1'b0;
        step();
        checks++; if (ce !== 1'b1) begin errors++; $display("FAIL release_ce: got %b exp 1", ce); end
        checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL release_pc0: got %h exp 80000000", pc); end
        step();
        checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL release_pc1: got %h exp 80000004", pc); end
        step();
        checks++; if (pc !== 32'h8000_0008) begin errors++; $display("FAIL release_pc2: got %h exp 80000008", pc); end
    endtask

    task automatic test_stall_ready();
        step(); step();
        checks++; if (pc !== 32'h8000_0010) begin errors++; $display("FAIL hold_start: got %h exp 80000010", pc); end
        stall = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== 32'h8000_0010) begin errors++; $display("FAIL hold_stall%0d: got %h exp 80000010", i, pc); end
        end
        stall = '0; if_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (pc !== 32'h8000_0010) begin errors++; $display("FAIL hold_ready%0d: got %h exp 80000010", i, pc); end
        end
        if_ready = 1'b1;
        step();
        checks++; if (pc !== 32'h8000_0014) begin errors++; $display("FAIL hold_release: got %h exp 80000014", pc); end
        checks++; if (mis !== 1'b0) begin errors++; $display("FAIL hold_mis: got %b exp 0", mis); end
    endtask

    task automatic test_branch_stall();
        stall = 6'b000001; br = 1'b1; tgt = 32'h8000_0100;
        step();
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL bs_pend1: got %b exp 1", pend); end
        checks++; if (pc !== 32'h8000_0014) begin errors++; $display("FAIL bs_pc1: got %h exp 80000014", pc); end
        tgt = 32'h8000_0200;
        step();
        br = 1'b0;
        step();
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL bs_pend2: got %b exp 1", pend); end
        checks++; if (pc !== 32'h8000_0014) begin errors++; $display("FAIL bs_pc2: got %h exp 80000014", pc); end
        stall = '0;
        step();
        checks++; if (pc !== 32'h8000_0200) begin errors++; $display("FAIL bs_apply: got %h exp 80000200", pc); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL bs_clear: got %b exp 0", pend); end
        step();
        checks++; if (pc !== 32'h8000_0204) begin errors++; $display("FAIL bs_next: got %h exp 80000204", pc); end
    endtask

    task automatic test_flush_priority();
        flush = 1'b1; new_pc = 32'h8000_0180; br = 1'b1; tgt = 32'h8000_0040; stall = 6'b000001;
        step();
        flush = 1'b0; br = 1'b0; stall = '0;
        checks++; if (pc !== 32'h8000_0180) begin errors++; $display("FAIL fl_pc: got %h exp 80000180", pc); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL fl_pend: got %b exp 0", pend); end
        step();
        checks++; if (pc !== 32'h8000_0184) begin errors++; $display("FAIL fl_next: got %h exp 80000184", pc); end
    endtask

    task automatic test_reset_mid();
        br = 1'b1; tgt = 32'h8000_0300;
        step();
        checks++; if (pc !== 32'h8000_0300) begin errors++; $display("FAIL rm_branch: got %h exp 80000300", pc); end
        stall = 6'b000001; tgt = 32'h8000_0400;
        step();
        br = 1'b0;
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL rm_pend: got %b exp 1", pend); end
        rst = 1'b1;
        step();
        checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL rm_pc: got %h exp 80000000", pc); end
        checks++; if (ce !== 1'b0) begin errors++; $display("FAIL rm_ce: got %b exp 0", ce); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL rm_pendclr: got %b exp 0", pend); end
        rst = 1'b0; stall = '0;
        step();
        checks++; if (pc !== 32'h8000_0000 || ce !== 1'b1) begin errors++; $display("FAIL rm_boot: got pc=%h ce=%b exp 80000000/1", pc, ce); end
        step();
        checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL rm_noapply: got %h exp 80000004", pc); end
    endtask

    task automatic test_boot_redirects();
        rst = 1'b1;
        step();
        rst = 1'b0; flush = 1'b1; new_pc = 32'h8000_0500;
        step();
        flush = 1'b0;
        checks++; if (pc !== 32'h8000_0500 || ce !== 1'b1) begin errors++; $display("FAIL boot_flush: got pc=%h ce=%b exp 80000500/1", pc, ce); end
        rst = 1'b1;
        step();
        rst = 1'b0; br = 1'b1; tgt = 32'h8000_0600;
        step();
        br = 1'b0;
        checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL boot_branch: got %h exp 80000000", pc); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL boot_pend: got %b exp 0", pend); end
        step();
        checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL boot_next: got %h exp 80000004", pc); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hF8; exp_seq[1] = 8'hFC; exp_seq[2] = 8'h00; exp_seq[3] = 8'h04;
        rst8 = 1'b1;
        step();
        rst8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (pc8 !== exp_seq[i]) begin errors++; $display("FAIL wrap%0d: got %h exp %h", i, pc8, exp_seq[i]); end
        end
        checks++; if (mis8 !== 1'b0) begin errors++; $display("FAIL wrap_mis0: got %b exp 0", mis8); end
        br8 = 1'b1; tgt8 = 8'h02;
        step();
        br8 = 1'b0;
        checks++; if (pc8 !== 8'h02) begin errors++; $display("FAIL mis_pc: got %h exp 02", pc8); end
        checks++; if (mis8 !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b exp 1", mis8); end
        step();
        checks++; if (pc8 !== 8'h06 || mis8 !== 1'b1) begin errors++; $display("FAIL mis_next: got %h/%b exp 06/1", pc8, mis8); end
    endtask

    initial begin
        test_reset();
        test_stall_ready();
        test_branch_stall();
        test_flush_priority();
        test_reset_mid();
        test_boot_redirects();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
